hundred_timer_arbiter: RTL
==========================

# hundred_timer_arbiter

Round-robin arbiter and sequencer that shares the single 100-cycle timeout counter among `N_REQ` requesters. It grants the timer to one requester at a time, drives the counter enable, detects the timeout, and returns a one-cycle `done` pulse to the winner. It also enforces the counter's release protocol so every run starts from a count of zero.

## Interface
- `N_REQ`, 4: number of requesters; legal range 2..8.
- `WD_LIMIT`, 127: watchdog cycle limit in RUN; used only with `TMR_WATCHDOG_EN`.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `req` in N_REQ: level request per requester; held until `done` or withdrawn.
- `gnt` out N_REQ: one-hot grant, registered.
- `done` out N_REQ: one-cycle completion pulse to the grant holder, registered.
- `busy` out 1: high in RUN and RELEASE.
- `err` out 1: sticky watchdog error; tied 0 without `TMR_WATCHDOG_EN`.
- `tmr_en` out 1: counter enable, combinational: `(state==RUN) && !tmr_timeout`.
- `tmr_timeout` in 1: counter timeout level. High after 100 enabled cycles; held while enabled; cleared on the edge after the enable drops.

## Operation
- Reset (`rst`=0 at an edge) produces state IDLE, `gnt`=0, `done`=0, `err`=0, and round-robin pointer 0. `busy`=0 and `tmr_en`=0 follow from the state.
- Reset takes priority mid-run. Any partial count left in the counter is cleared by that counter's own reset, which shares `rst`.
- States:
  - IDLE
    - If any `req` bit is set: pick the first set bit at or after the pointer, modulo N_REQ.
    - Set `gnt` one-hot for the winner, set pointer = winner+1 mod N_REQ, go to RUN.
    - Otherwise stay in IDLE.
  - RUN
    - `tmr_en` is high until `tmr_timeout` is seen.
    - On the edge where `tmr_timeout`=1: clear `gnt`.
    - Pulse `done[winner]` only if `req[winner]` is still 1 at that edge; otherwise emit no pulse.
    - Go to RELEASE.
  - RELEASE
    - Wait until `tmr_timeout`=0, then go to IDLE.
    - Do not grant in this state.
- Withdrawn request: dropping `req[winner]` during RUN does not abort the run. The counter has no clear input, so the run completes to timeout and the `done` pulse is suppressed.
- The combinational gating of `tmr_en` guarantees the counter sees enable low on the edge after its timeout rises. The counter therefore wraps to 0 and stays there, and no residual count carries into the next grant.
- Requests arriving during RUN or RELEASE wait in IDLE arbitration. No request is lost as long as it is held.
- At most one `gnt` bit and at most one `done` bit are high in any cycle.

## Timing
- Grant latency: `req` sampled in IDLE at edge k produces `gnt` high from edge k+1 (= g).
- `tmr_en` is high from g through the cycle before g+100.
- `tmr_timeout` rises at edge g+100.
- `done` is high for exactly one cycle from edge g+101. `gnt` falls at that same edge.
- State is RELEASE from g+101 and IDLE at g+102. The earliest next grant is at g+103.
- Back-to-back service: 103 cycles per grant when requests are continuously pending.

## Configuration
- `TMR_WATCHDOG_EN` defined:
  - An 8-bit watchdog counts cycles in RUN.
  - If it reaches `WD_LIMIT` without `tmr_timeout`, set `err`=1 (sticky until reset), clear `gnt`, emit no `done`, and go to RELEASE.
  - The watchdog clears on entry to RUN.
- `TMR_WATCHDOG_EN` not defined: no watchdog logic, `err` constant 0, and RUN waits indefinitely for `tmr_timeout`.
- `WD_LIMIT` must exceed 100.

## Test plan
- Single request: reset, then hold `req`=0001 with the real counter attached. Expect `gnt`=0001 one cycle later, `done`=0001 for exactly 1 cycle at 101 cycles after `gnt` rises, and `tmr_en` high for exactly 100 cycles.
- Round-robin: hold `req`=1111 continuously. Expect grants in order 0001, 0010, 0100, 1000, 0001, spaced 103 cycles apart, with every run lasting exactly 100 enabled cycles (no residual count).
- Withdrawal: grant `req[2]`, drop it 40 cycles into RUN. Expect the run to still end at 100 cycles, no `done` pulse, and the next pending requester granted at g+103.
- Reset mid-run: assert `rst`=0 at cycle 50 of RUN. Expect `gnt`=0, `busy`=0, `tmr_en`=0 next cycle. After release, a new single request completes in exactly 101 cycles.
- Pointer fairness: start with `req`=1000 (grant 3), then `req`=0101 pending. Expect the next grant to go to 0001 (bit 0), then 0100.
- Watchdog (`TMR_WATCHDOG_EN`, `WD_LIMIT`=127): stub `tmr_timeout`=0. Expect `err`=1 after 127 RUN cycles, `gnt` cleared, no `done`, and return to IDLE.

Source files
------------

// File: rtl/hundred_timer_arbiter.sv
// hundred_timer_arbiter: round-robin arbiter and sequencer for the shared 100-cycle timeout
// counter. Grants the counter to one requester at a time and gates its enable so that every
// run starts from a count of zero. Returns a one-cycle done pulse to the winner.
//
// Optional feature: define TMR_WATCHDOG_EN to add an 8-bit RUN-state watchdog. The watchdog
// raises a sticky err after WD_LIMIT cycles without a timeout. Without the macro, err is
// tied low and RUN waits indefinitely.
module hundred_timer_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned WD_LIMIT = 127
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] done,
    output logic             busy,
    output logic             err,
    output logic             tmr_en,
    input  logic             tmr_timeout
);

    localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StRelease
    } state_e;

    state_e          state;
    logic [PtrW-1:0] ptr;

    logic             pick_valid;
    logic [PtrW-1:0]  pick_idx;
    logic [PtrW-1:0]  ptr_next;
    logic [N_REQ-1:0] pick_oh;

`ifdef TMR_WATCHDOG_EN
    localparam logic [7:0] WdLast = 8'(WD_LIMIT - 1);

    logic [7:0] wd_cnt;
    logic       err_q;
`endif

    // Round-robin pick: first set request at or after the pointer, wrapping modulo N_REQ.
    always_comb begin : p_pick
        int idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        // Walk offsets from far to near so the nearest set bit is the last one written.
        for (int off = int'(N_REQ) - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % int'(N_REQ);
            if (req[PtrW'(idx)]) begin
                pick_valid = 1'b1;
                pick_idx   = PtrW'(idx);
            end
        end
        ptr_next          = PtrW'((int'(pick_idx) + 1) % int'(N_REQ));
        pick_oh           = '0;
        pick_oh[pick_idx] = pick_valid;
    end

    // Counter enable is gated by the timeout itself, so the counter sees enable low on the
    // edge after timeout rises and wraps back to zero before the next grant.
    assign tmr_en = (state == StRun) && !tmr_timeout;

    assign busy = (state == StRun) || (state == StRelease);

`ifdef TMR_WATCHDOG_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Arbitration FSM with registered grant, done and pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= StIdle;
            gnt   <= '0;
            done  <= '0;
            ptr   <= '0;
`ifdef TMR_WATCHDOG_EN
            wd_cnt <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            done <= '0;
            unique case (state)
                StIdle: begin
                    if (pick_valid) begin
                        gnt   <= pick_oh;
                        ptr   <= ptr_next;
                        state <= StRun;
`ifdef TMR_WATCHDOG_EN
                        wd_cnt <= '0;
`endif
                    end
                end
                StRun: begin
                    if (tmr_timeout) begin
                        gnt   <= '0;
                        // gnt is one-hot for the winner; a withdrawn request suppresses done.
                        if (|(req & gnt)) begin
                            done <= gnt;
                        end
                        state <= StRelease;
                    end
`ifdef TMR_WATCHDOG_EN
                    else if (wd_cnt == WdLast) begin
                        err_q <= 1'b1;
                        gnt   <= '0;
                        state <= StRelease;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
`endif
                end
                StRelease: begin
                    // Hold off new grants until the counter has dropped its timeout.
                    if (!tmr_timeout) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                    gnt   <= '0;
                end
            endcase
        end
    end

    // Simulation-only guards on configuration and on grant/done exclusivity.
    always_ff @(posedge clk) begin
        assert (N_REQ >= 2 && N_REQ <= 8 && WD_LIMIT > 100 && WD_LIMIT < 256);
        if (rst) begin
            assert ($onehot0(gnt));
            assert ($onehot0(done));
        end
    end

endmodule
